// File: rtl/alu_op_scheduler.sv
// ============================================================================
// Module  : alu_op_scheduler
// Brief   : Round-robin scheduler sharing one ALU between two requesters.
//           It sequences load-A, load-B, execute, wait and respond, then
//           returns the result tagged with the requester id.
//           Optional macro ALU_SCHED_TIMEOUT_EN adds a WAIT-state watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_scheduler #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_ld_a,
    output logic         alu_ld_b,
    output logic         alu_cmp,
    output logic         alu_add,
    output logic         alu_sub,
    output logic         alu_div,
    output logic         alu_mul,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_A = 3'd1,
        S_LD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_CMP = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_DIV = 4'b0100;
    localparam logic [3:0] c_OP_MUL = 4'b0101;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_rr;
    logic [3:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_id;
    logic [W-1:0]   r_result;
    logic           r_err;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_accept;
    logic [3:0]     w_sel_op;
    logic           w_sel_legal;
    logic           w_done;
    logic           w_timeout;

    // When both requesters are valid the rr pointer picks the winner.
    assign w_grant0    = req0_valid & (~req1_valid | ~r_rr);
    assign w_grant1    = req1_valid & (~req0_valid |  r_rr);
    assign w_accept    = (r_state == S_IDLE) & (w_grant0 | w_grant1);
    assign w_sel_op    = w_grant1 ? req1_op : req0_op;
    assign w_sel_legal = (w_sel_op >= c_OP_CMP) && (w_sel_op <= c_OP_MUL);
    assign w_done      = (r_state == S_WAIT) & alu_done;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A late alu_done on the limit cycle still wins over the watchdog.
    assign w_timeout = (r_state == S_WAIT) & ~alu_done & (r_cnt == c_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_ld_a    = 1'b0;
        alu_ld_b    = 1'b0;
        alu_cmp     = 1'b0;
        alu_add     = 1'b0;
        alu_sub     = 1'b0;
        alu_div     = 1'b0;
        alu_mul     = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 | w_grant1) begin
                    w_state_nxt = w_sel_legal ? S_LD_A : S_RESP;
                end
            end
            S_LD_A: begin
                alu_ld_a    = 1'b1;
                w_state_nxt = S_LD_B;
            end
            S_LD_B: begin
                alu_ld_b    = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_cmp     = (r_op == c_OP_CMP);
                alu_add     = (r_op == c_OP_ADD);
                alu_sub     = (r_op == c_OP_SUB);
                alu_div     = (r_op == c_OP_DIV);
                alu_mul     = (r_op == c_OP_MUL);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr     <= 1'b0;
            r_op     <= 4'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= w_sel_op;
                r_a   <= w_grant1 ? req1_a : req0_a;
                r_b   <= w_grant1 ? req1_b : req0_b;
                r_id  <= w_grant1;
                r_err <= ~w_sel_legal;
                if (!w_sel_legal) begin
                    r_result <= '0;
                end
            end
            if (w_done) begin
                r_result <= alu_result;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_result <= '0;
                r_err    <= 1'b1;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rr <= ~r_id;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
// ============================================================================
// Module  : tb_alu_op_scheduler
// Brief   : Directed, table-driven bench for alu_op_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 4'd0, req1_op = 4'd0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_ld_a, alu_ld_b, alu_cmp, alu_add, alu_sub, alu_div, alu_mul;
    logic         alu_done = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_err;

    int n_checks = 0;
    int n_err    = 0;

    alu_op_scheduler #(.W(W), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ld_a   (alu_ld_a),
        .alu_ld_b   (alu_ld_b),
        .alu_cmp    (alu_cmp),
        .alu_add    (alu_add),
        .alu_sub    (alu_sub),
        .alu_div    (alu_div),
        .alu_mul    (alu_mul),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    wire [6:0] w_strb = {alu_ld_a, alu_ld_b, alu_cmp, alu_add, alu_sub, alu_div, alu_mul};

    typedef struct {
        logic         id;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] alu_res;
        logic         exp_err;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [4:0] op_onehot(input logic [3:0] op);
        case (op)
            4'b0001: return 5'b10000;
            4'b0010: return 5'b01000;
            4'b0011: return 5'b00100;
            4'b0100: return 5'b00010;
            4'b0101: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the LD_A/RESP negedge.
    task automatic issue(input logic id, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        check("ready_on_request", id ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Starts at the LD_A negedge; returns at the RESP negedge.
    task automatic exec_phase(input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] res);
        check("ld_a_strobe", w_strb, 7'b1000000);
        check("alu_a_at_ld_a", alu_a, a);
        @(negedge clk);
        check("ld_b_strobe", w_strb, 7'b0100000);
        check("alu_b_at_ld_b", alu_b, b);
        @(negedge clk);
        check("op_strobe", w_strb, {2'b00, op_onehot(op)});
        check("alu_a_stable", alu_a, a);
        @(negedge clk);
        check("wait_quiet", {w_strb, rsp_valid}, 8'h00);
        alu_done = 1'b1; alu_result = res;
        @(negedge clk);
        alu_done = 1'b0; alu_result = '0;
    endtask

    task automatic check_resp(input logic id, input logic [W-1:0] res, input logic err);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_result", rsp_result, res);
        check("rsp_err", rsp_err, err);
    endtask

    task automatic finish_resp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drops", rsp_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outputs", {w_strb, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}, 0);
        check("reset_buses", {alu_a, alu_b, rsp_result}, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'b0010, 8'h05, 8'h03, 8'h08, 1'b0, 8'h08};
        vecs[1] = '{1'b1, 4'b0011, 8'h09, 8'h04, 8'h05, 1'b0, 8'h05};
        vecs[2] = '{1'b0, 4'b0001, 8'h07, 8'h07, 8'h01, 1'b0, 8'h01};
        vecs[3] = '{1'b1, 4'b0100, 8'h20, 8'h04, 8'h08, 1'b0, 8'h08};
        vecs[4] = '{1'b0, 4'b0101, 8'h03, 8'h05, 8'h0F, 1'b0, 8'h0F};
        vecs[5] = '{1'b1, 4'b0111, 8'h11, 8'h22, 8'hAA, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 4'b0000, 8'h33, 8'h44, 8'hAA, 1'b1, 8'h00};
        vecs[7] = '{1'b1, 4'b1111, 8'h55, 8'h66, 8'hAA, 1'b1, 8'h00};
        vecs[8] = '{1'b0, 4'b0010, 8'hFF, 8'h01, 8'h00, 1'b0, 8'h00};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs_initial", {w_strb, rsp_valid, rsp_id, rsp_err}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven single operations, legal and illegal opcodes.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].exp_err) begin
                check("illegal_no_strobes", w_strb, 0);
            end else begin
                exec_phase(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].alu_res);
            end
            check_resp(vecs[i].id, vecs[i].exp_res, vecs[i].exp_err);
            finish_resp();
        end

        // Backpressure: response held 10 cycles while req0 waits.
        issue(1'b0, 4'b0010, 8'h11, 8'h22);
        exec_phase(4'b0010, 8'h11, 8'h22, 8'h33);
        req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 8'h50; req0_b = 8'h10;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_req0_blocked", req0_ready, 0);
            check_resp(1'b0, 8'h33, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_after_handshake", rsp_valid, 0);
        check("bp_req0_accepted", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        exec_phase(4'b0011, 8'h50, 8'h10, 8'h40);
        check_resp(1'b0, 8'h40, 1'b0);
        finish_resp();

        // Contention: both valid, grants must alternate starting from req0.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_op = 4'b0101; req1_a = 8'h02; req1_b = 8'h03;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n_ops;
            logic [4:0] seen;
            n_ops = 0;
            seen  = 5'b0;
            #1;
            check("rr_grant0", req0_ready, (k % 2) == 0);
            check("rr_grant1", req1_ready, (k % 2) == 1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_ops += $countones(w_strb[4:0]);
                seen  |= w_strb[4:0];
            end
            check("rr_one_strobe", n_ops, 1);
            check("rr_strobe_kind", seen, (k % 2) ? 5'b00001 : 5'b01000);
            @(negedge clk);
            alu_done = 1'b1; alu_result = 8'hC0 + 8'(k);
            @(negedge clk);
            alu_done = 1'b0;
            check("rr_rsp_id", rsp_id, k % 2);
            check("rr_rsp_result", rsp_result, 8'hC0 + 8'(k));
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);

        // Reset in WAIT of a MUL drops it; stray alu_done in IDLE is ignored.
        issue(1'b0, 4'b0101, 8'h04, 8'h05);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midop_reset_ctrl", {w_strb, rsp_valid, rsp_id, rsp_err}, 0);
        check("midop_reset_buses", {alu_a, alu_b, rsp_result}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_done = 1'b1; alu_result = 8'h14;
            @(negedge clk);
            check("no_rsp_after_reset", {rsp_valid, w_strb}, 0);
        end
        alu_done = 1'b0; alu_result = '0;
        issue(1'b1, 4'b0011, 8'h0A, 8'h03);
        exec_phase(4'b0011, 8'h0A, 8'h03, 8'h07);
        check_resp(1'b1, 8'h07, 1'b0);
        finish_resp();

`ifdef ALU_SCHED_TIMEOUT_EN
        // Watchdog: DIV never completes.
        issue(1'b0, 4'b0100, 8'h09, 8'h00);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_still_waiting", rsp_valid, 0);
        end
        @(negedge clk);
        check_resp(1'b0, 8'h00, 1'b1);
        finish_resp();
        alu_done = 1'b1; alu_result = 8'h99;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        check("to_late_done_ignored", {rsp_valid, w_strb}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one ALU datapath between two requesters. The ALU has load-A and load-B strobes, one-hot operation strobes for cmp/add/sub/div/mul, and a done/result return.
- Arbitrates round-robin, sequences the load-A → load-B → execute → wait → respond steps, and returns the result tagged with the requester id.
- Sits between the operand sources (host/test sequencer) and the ALU datapath. It replaces hand-driven strobe sequencing.

Parameters:
- W, 8, operand and result width
- TIMEOUT, 16, watchdog cycle limit in WAIT; used only when ALU_SCHED_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  opcode: 0001 CMP, 0010 ADD, 0011 SUB, 0100 DIV, 0101 MUL
- req0_a, req0_b  in  W  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
- alu_a, alu_b  out  W  operand buses to the ALU
- alu_ld_a, alu_ld_b  out  1  one-cycle operand load strobes
- alu_cmp, alu_add, alu_sub, alu_div, alu_mul  out  1  one-hot, one-cycle op strobes
- alu_done  in  1  ALU result valid
- alu_result  in  W  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  W  captured result
- rsp_err  out  1  illegal opcode (or timeout when the feature is enabled)

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, rr pointer=0 (req0 has priority).
  - All outputs 0, including alu_a/alu_b/rsp_result.
  - Any in-flight operation is dropped with no response, even mid-WAIT or mid-RESP.
- FSM states: IDLE, LD_A, LD_B, EXEC, WAIT, RESP. Encoding is free.
- Output timing:
  - All ALU-side and rsp_* outputs are registered or decoded from the state register only.
  - reqN_ready is the only combinational output: (state==IDLE) & grantN.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant req[rr].
  - On grant, capture op, a, b and id.
  - Legal opcode → LD_A.
  - Illegal opcode (0000, 0110–1111) → RESP with rsp_err=1 and rsp_result=0. No ALU strobes are issued.
- LD_A: alu_ld_a=1 for one cycle; alu_a holds the captured a → LD_B.
- LD_B: alu_ld_b=1 for one cycle; alu_b holds the captured b → EXEC.
  - alu_a and alu_b stay stable from LD_A until return to IDLE.
- EXEC: exactly one op strobe, matching the opcode, high for one cycle → WAIT.
- WAIT:
  - Hold until alu_done=1, then capture alu_result into rsp_result with rsp_err=0 → RESP.
  - alu_done is ignored in every state other than WAIT.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
  - On the handshake: rr = ~rsp_id, rsp_valid drops next cycle, state → IDLE.
  - rsp_ready high in any other state has no effect.
- Latency:
  - Accept cycle T → alu_ld_a at T+1, alu_ld_b at T+2, op strobe at T+3.
  - Earliest alu_done is sampled at T+4, giving rsp_valid at T+5.
  - Illegal opcode gives rsp_valid at T+1.
- Throughput: one operation in flight. No acceptance from RESP until the cycle after the handshake, so back-to-back requests are separated by at least one IDLE cycle.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_SCHED_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT+1)) clears on entry to WAIT.
  - If TIMEOUT cycles pass in WAIT without alu_done → RESP with rsp_err=1 and rsp_result=0.
  - alu_done arriving in the same cycle the limit is reached wins (normal response).
- Undefined: no counter; WAIT holds indefinitely; rsp_err reports illegal opcodes only.

Test Plan:
- Single ADD: req0 op=0010, a=8'h05, b=8'h03, alu_done one cycle after the strobe with result 8'h08 → alu_ld_a T+1, alu_ld_b T+2, alu_add T+3, rsp_valid T+5, rsp_id=0, rsp_result=8'h08, rsp_err=0.
- Contention: req0 and req1 valid every cycle, rsp_ready=1, four operations → grant order 0,1,0,1; exactly one op strobe per operation.
- Illegal opcode: req1 op=0111 → no alu_* strobes; rsp_valid at T+1 with rsp_id=1, rsp_err=1, rsp_result=0.
- Backpressure: rsp_ready=0 for 10 cycles during RESP with req0 valid → rsp_* stable, req0_ready=0 throughout; req0 is accepted the cycle after rsp_ready=1 → IDLE.
- Reset mid-op: reset=0 asserted in WAIT of a MUL → all outputs 0 immediately; after release, a new req1 SUB completes normally and no response is ever issued for the MUL.
- Timeout (macro defined, TIMEOUT=16): DIV with alu_done never asserted → rsp_err=1 and rsp_result=0 after 16 WAIT cycles; alu_done pulsed in a later IDLE is ignored.
